// File: rtl/psw_debouncer.sv
// Push-switch debouncer: two-flop synchroniser, shared sample prescaler and a per-channel stability counter.
// Optional macro PSW_DEBOUNCE_PRESS_PULSE_EN adds sw_press, a one-cycle pulse on each debounced 1->0 edge.
module psw_debouncer #(
  parameter int WIDTH        = 4,
  parameter int DIV_COUNT    = 50000,
  parameter int STABLE_TICKS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
  output logic [WIDTH-1:0] sw_press,
`endif
  output logic             tick
);

  localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [DIV_W-1:0] prescale;
  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] out_next;
`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
  logic [WIDTH-1:0] press_next;
`endif

  // Released is the safe idle level, so the synchroniser resets to all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= '0;
      tick     <= 1'b0;
    end else begin
      tick <= (prescale == DIV_LAST);
      if (prescale == DIV_LAST) begin
        prescale <= '0;
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

  // Any sample agreeing with the current output restarts qualification from zero.
  always_comb begin
    cnt_next = cnt;
    out_next = sw_out;
`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
    press_next = '0;
`endif
    for (int i = 0; i < WIDTH; i++) begin
      if (s2[i] == sw_out[i]) begin
        cnt_next[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_LAST) begin
          out_next[i] = s2[i];
          cnt_next[i] = '0;
`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
          press_next[i] = ~s2[i];
`endif
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_out <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sw_out <= out_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_press <= '0;
    end else begin
      sw_press <= press_next;
    end
  end
`endif

endmodule

// File: tb/tb_psw_debouncer.sv
// Directed bench for psw_debouncer with WIDTH=4, DIV_COUNT=4, STABLE_TICKS=3.
// Define PSW_DEBOUNCE_PRESS_PULSE_EN to also exercise the sw_press output.
module tb_psw_debouncer;

  logic       clk;
  logic       reset;
  logic [3:0] sw_in;
  logic [3:0] sw_out;
  logic       tick;
`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
  logic [3:0] sw_press;
`endif

  int checks = 0;
  int errors = 0;

  psw_debouncer #(
    .WIDTH(4),
    .DIV_COUNT(4),
    .STABLE_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_in(sw_in),
    .sw_out(sw_out),
`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
    .sw_press(sw_press),
`endif
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge, half a cycle before the next sampling edge.
  task automatic applyStimulus(input logic [3:0] value);
    @(negedge clk);
    sw_in = value;
  endtask

  // Counts rising edges until sw_out leaves its starting value; -1 on timeout.
  task automatic waitChange(input logic [3:0] start, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (sw_out !== start) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int bad;
    int seen;

    reset = 1'b1;
    sw_in = 4'hF;
    #12;
    checkOutput("reset_sw_out", {28'd0, sw_out}, 32'hF);
    checkOutput("reset_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Tick first rises after the 4th edge from release, then every 4 cycles.
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("idle_tick_%0d", n), {31'd0, tick}, {31'd0, (n % 4 == 0)});
    end
    checkOutput("idle_sw_out", {28'd0, sw_out}, 32'hF);

    // Single channel press and release.
    applyStimulus(4'hE);
    waitChange(4'hF, lat);
    checkOutput("press0_latency_ok", {31'd0, (lat >= 11 && lat <= 15)}, 32'd1);
    checkOutput("press0_value", {28'd0, sw_out}, 32'hE);
    applyStimulus(4'hF);
    waitChange(4'hE, lat);
    checkOutput("release0_latency_ok", {31'd0, (lat >= 11 && lat <= 15)}, 32'd1);
    checkOutput("release0_value", {28'd0, sw_out}, 32'hF);

    // Six-cycle bounces on bit 1 can never collect three ticks.
    bad = 0;
    for (int r = 0; r < 5; r++) begin
      applyStimulus(4'hD);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (sw_out !== 4'hF) bad++;
      end
      applyStimulus(4'hF);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (sw_out !== 4'hF) bad++;
      end
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (sw_out !== 4'hF) bad++;
    end
    checkOutput("glitch_bad_cycles", bad, 32'd0);
    checkOutput("glitch_sw_out", {28'd0, sw_out}, 32'hF);

    // All channels together must move in one step.
    applyStimulus(4'h0);
    waitChange(4'hF, lat);
    checkOutput("all_press_latency_ok", {31'd0, (lat >= 11 && lat <= 15)}, 32'd1);
    checkOutput("all_press_value", {28'd0, sw_out}, 32'h0);
    applyStimulus(4'hF);
    waitChange(4'h0, lat);
    checkOutput("all_release_latency_ok", {31'd0, (lat >= 11 && lat <= 15)}, 32'd1);
    checkOutput("all_release_value", {28'd0, sw_out}, 32'hF);

    // Reset part-way through qualifying bit 2.
    applyStimulus(4'hB);
    seen = 0;
    for (int n = 0; n < 40 && seen < 2; n++) begin
      @(posedge clk);
      #1;
      if (tick) seen++;
    end
    checkOutput("midreset_ticks_seen", seen, 32'd2);
    checkOutput("midreset_pre_value", {28'd0, sw_out}, 32'hF);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_async_value", {28'd0, sw_out}, 32'hF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midreset_hold_value", {28'd0, sw_out}, 32'hF);
    checkOutput("midreset_hold_tick", {31'd0, tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    waitChange(4'hF, lat);
    checkOutput("midreset_latency", lat, 32'd13);
    checkOutput("midreset_value", {28'd0, sw_out}, 32'hB);
    applyStimulus(4'hF);
    waitChange(4'hB, lat);
    checkOutput("midreset_release_value", {28'd0, sw_out}, 32'hF);

`ifdef PSW_DEBOUNCE_PRESS_PULSE_EN
    begin
      int pulses;
      int together;
      pulses = 0;
      together = 0;
      applyStimulus(4'h7);
      for (int n = 0; n < 40; n++) begin
        @(posedge clk);
        #1;
        if (sw_press !== 4'h0) begin
          pulses++;
          if (sw_press === 4'h8 && sw_out === 4'h7) together++;
        end
      end
      checkOutput("press3_pulse_count", pulses, 32'd1);
      checkOutput("press3_pulse_coincident", together, 32'd1);
      checkOutput("press3_value", {28'd0, sw_out}, 32'h7);
      pulses = 0;
      applyStimulus(4'hF);
      for (int n = 0; n < 40; n++) begin
        @(posedge clk);
        #1;
        if (sw_press !== 4'h0) pulses++;
      end
      checkOutput("release3_pulse_count", pulses, 32'd0);
      checkOutput("release3_value", {28'd0, sw_out}, 32'hF);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
